// File: rtl/mul_div_unit_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M multiply/divide unit.
package mul_div_pkg;
    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic is_div(op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(op_e op);
        return op[2] & op[1];
    endfunction

    function automatic logic a_signed(op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic b_signed(op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction
endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the execute stage (master) and the mul/div unit (slave).
interface mul_div_unit_if #(parameter int XLEN = mul_div_pkg::XLEN);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, funct3, op_a, op_b, input busy, done, result);
    modport slave  (input start, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/mul_div_unit_step.sv
// One iteration: LSB-first shift-add (multiply) or restoring shift-subtract (divide).
module mul_div_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    input  logic              div_mode_i,
    output logic [2*XLEN-1:0] acc_o
);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   rshift;
    logic [XLEN+1:0] diff;

    always_comb begin
        sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        rshift = acc_i[2*XLEN-1:XLEN-1];
        diff   = {1'b0, rshift} - {2'b00, opnd_i};
        // divide: acc = {remainder, dividend bits shifting out / quotient bits shifting in}
        if (div_mode_i) begin
            if (diff[XLEN+1]) acc_o = {rshift[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            else              acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
        end else begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M unit: magnitudes in, XLEN steps, sign fix-up; div-by-zero/overflow finish at once.
// IDLE: wait for start | RUN: one step per cycle | DONE: done pulse, result valid
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int XLEN = mul_div_pkg::XLEN
) (
    input logic          clk,
    input logic          rst,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q;
    op_e               op_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opnd_q;
    logic              neg_q;
    logic [CW-1:0]     cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    op_e               op_in;
    logic              a_neg_d, b_neg_d, neg_d, special_d;
    logic [XLEN-1:0]   mag_a_d, mag_b_d, special_res_d, result_d;
    logic [2*XLEN-1:0] step_out, prod_d;

    mul_div_step #(.XLEN(XLEN)) u_step (
        .acc_i      (acc_q),
        .opnd_i     (opnd_q),
        .div_mode_i (is_div(op_q)),
        .acc_o      (step_out)
    );

    always_comb begin
        op_in   = op_e'(bus.funct3);
        a_neg_d = a_signed(op_in) && bus.op_a[XLEN-1];
        b_neg_d = b_signed(op_in) && bus.op_b[XLEN-1];
        mag_a_d = a_neg_d ? -bus.op_a : bus.op_a;
        mag_b_d = b_neg_d ? -bus.op_b : bus.op_b;
        neg_d   = is_rem(op_in) ? a_neg_d : (a_neg_d ^ b_neg_d);

        special_d     = 1'b0;
        special_res_d = '0;
        if (is_div(op_in) && bus.op_b == '0) begin
            special_d     = 1'b1;
            special_res_d = is_rem(op_in) ? bus.op_a : '1;
        end else if ((op_in == OP_DIV || op_in == OP_REM) &&
                     bus.op_a == MIN_NEG && bus.op_b == '1) begin
            special_d     = 1'b1;
            special_res_d = is_rem(op_in) ? '0 : MIN_NEG;
        end

        prod_d = neg_q ? -step_out : step_out;
        case (op_q)
            OP_MUL:          result_d = prod_d[XLEN-1:0];
            OP_DIV, OP_DIVU: result_d = neg_q ? -step_out[XLEN-1:0] : step_out[XLEN-1:0];
            OP_REM, OP_REMU: result_d = neg_q ? -step_out[2*XLEN-1:XLEN] : step_out[2*XLEN-1:XLEN];
            default:         result_d = prod_d[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q   <= op_in;
                        neg_q  <= neg_d;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (special_d) begin
                            result_q <= special_res_d;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            // multiply shifts the multiplier out of acc; divide shifts the dividend
                            acc_q   <= {{XLEN{1'b0}}, is_div(op_in) ? mag_a_d : mag_b_d};
                            opnd_q  <= is_div(op_in) ? mag_b_d : mag_a_d;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_q <= step_out;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        result_q <= result_d;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised and directed checks of mul_div_unit against a 64-bit arithmetic reference model.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_div_unit_if bus ();
    mul_div_unit dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_exp;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        q  = 0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                q = sa / sb; return q[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                q = longint'(ua / ub); return q[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                q = sa % sb; return q[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                q = longint'(ua % ub); return q[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // poke: cycle after acceptance in which a spurious start is raised (0 = none)
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int poke);
        int lat;
        logic held_ok;
        logic [31:0] exp_r;
        exp_r = ref_res(op, a, b);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = op; bus.op_a = a; bus.op_b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.funct3 = 3'($urandom); bus.op_a = $urandom; bus.op_b = $urandom;
        lat = 1;
        held_ok = 1'b1;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.result !== last_exp || bus.busy !== 1'b1) held_ok = 1'b0;
            @(negedge clk);
            lat++;
            bus.start = (lat == poke);
        end
        bus.start = 1'b0;
        expect_eq({tag, "_lat"}, 64'(lat), 64'(ref_lat(op, a, b)));
        expect_eq({tag, "_res"}, 64'(bus.result), 64'(exp_r));
        expect_eq({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
        expect_eq({tag, "_held"}, 64'(held_ok), 64'd1);
        last_exp = exp_r;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_done;
        rst = 1'b1;
        bus.start = 1'b0; bus.funct3 = 3'd0; bus.op_a = '0; bus.op_b = '0;
        repeat (3) @(negedge clk);
        expect_eq("rst_busy", 64'(bus.busy), 64'd0);
        expect_eq("rst_done", 64'(bus.done), 64'd0);
        expect_eq("rst_result", 64'(bus.result), 64'd0);
        rst = 1'b0;
        last_exp = '0;

        do_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        repeat (7) @(negedge clk);
        expect_eq("mul_hold", 64'(bus.result), 64'h0000_0000_FFFF_FFEB);
        expect_eq("idle_busy", 64'(bus.busy), 64'd0);
        expect_eq("idle_done", 64'(bus.done), 64'd0);

        do_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        do_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        do_op("remu",   3'd7, 32'd100, 32'd7, 0);
        do_op("divu0",  3'd5, 32'd5, 32'd0, 0);
        do_op("rem0",   3'd6, 32'd5, 32'd0, 0);
        do_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("mul_poke", 3'd0, 32'd3, 32'd5, 5);
        do_op("divu",   3'd5, 32'd100, 32'd7, 0);

        // abort a divide with reset in cycle 10 after acceptance
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd4; bus.op_a = 32'd1000; bus.op_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_eq("abort_busy", 64'(bus.busy), 64'd0);
        expect_eq("abort_done", 64'(bus.done), 64'd0);
        expect_eq("abort_result", 64'(bus.result), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        expect_eq("abort_no_done", 64'(saw_done), 64'd0);
        last_exp = '0;

        for (int i = 0; i < 150; i++) begin
            logic [2:0] op;
            int poke;
            op = 3'($urandom);
            poke = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32)) : 0;
            do_op("rand", op, pick(), pick(), poke);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
